// File: rtl/xor_parity_rx.sv
// rtl/xor_parity_rx.sv - serial frame receiver with XOR parity and stop-bit checking
module xor_parity_rx #(
  parameter int DATA_W = 8,
  parameter int ODD    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_bit,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
  localparam logic ODD_BIT = (ODD != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_acc;
  logic                r_perr_q;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_data_valid;
  logic                r_parity_err;
  logic                r_frame_err;
  logic                w_perr;

  assign w_perr = (r_acc ^ rx_bit) ^ ODD_BIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (rx_valid) begin
      case (r_state)
        S_IDLE:   if (!rx_bit) w_state_nxt = S_DATA;
        S_DATA:   if (r_cnt == LAST_IDX) w_state_nxt = S_PARITY;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  // Datapath and registered result pulses; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_shift      <= '0;
      r_acc        <= 1'b0;
      r_perr_q     <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      if (rx_valid) begin
        case (r_state)
          S_IDLE: begin
            if (!rx_bit) begin
              r_cnt <= '0;
              r_acc <= 1'b0;
            end
          end
          S_DATA: begin
            for (int i = 0; i < DATA_W; i++) begin
              if (r_cnt == CNT_W'(i)) r_shift[i] <= rx_bit;
            end
            r_acc <= r_acc ^ rx_bit;
            r_cnt <= r_cnt + 1'b1;
          end
          S_PARITY: r_perr_q <= w_perr;
          S_STOP: begin
            if (rx_bit) begin
              r_data_out   <= r_shift;
              r_data_valid <= 1'b1;
              r_parity_err <= r_perr_q;
            end else begin
              r_frame_err  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_xor_parity_rx.sv
// tb/tb_xor_parity_rx.sv - directed bench for xor_parity_rx (even and odd parity instances)
module tb_xor_parity_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_bit;
  logic       rx_valid0;
  logic       rx_valid1;
  logic [7:0] data_out0, data_out1;
  logic       data_valid0, data_valid1;
  logic       parity_err0, parity_err1;
  logic       frame_err0, frame_err1;
  logic       busy0, busy1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xor_parity_rx #(.DATA_W(8), .ODD(0)) dut_even (
    .clk        (clk),
    .rst        (rst),
    .rx_bit     (rx_bit),
    .rx_valid   (rx_valid0),
    .data_out   (data_out0),
    .data_valid (data_valid0),
    .parity_err (parity_err0),
    .frame_err  (frame_err0),
    .busy       (busy0)
  );

  xor_parity_rx #(.DATA_W(8), .ODD(1)) dut_odd (
    .clk        (clk),
    .rst        (rst),
    .rx_bit     (rx_bit),
    .rx_valid   (rx_valid1),
    .data_out   (data_out1),
    .data_valid (data_valid1),
    .parity_err (parity_err1),
    .frame_err  (frame_err1),
    .busy       (busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input int dev, input logic b, input int gap);
    repeat (gap) tick();
    rx_bit = b;
    if (dev == 0) rx_valid0 = 1'b1;
    else          rx_valid1 = 1'b1;
    tick();
    rx_valid0 = 1'b0;
    rx_valid1 = 1'b0;
  endtask

  function automatic int pick_gap(input int maxgap);
    return (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
  endfunction

  task automatic send_frame(input int dev, input logic [7:0] d, input logic par,
                            input logic stop, input int maxgap);
    send_bit(dev, 1'b0, pick_gap(maxgap));
    for (int i = 0; i < 8; i++) send_bit(dev, d[i], pick_gap(maxgap));
    send_bit(dev, par, pick_gap(maxgap));
    send_bit(dev, stop, pick_gap(maxgap));
  endtask

  initial begin
    rst       = 1'b1;
    rx_bit    = 1'b1;
    rx_valid0 = 1'b0;
    rx_valid1 = 1'b0;
    tick();
    tick();
    chk("rst_data_out", 16'(data_out0), 16'h0000);
    chk("rst_data_valid", 16'(data_valid0), 16'h0);
    chk("rst_parity_err", 16'(parity_err0), 16'h0);
    chk("rst_frame_err", 16'(frame_err0), 16'h0);
    chk("rst_busy", 16'(busy0), 16'h0);
    rst = 1'b0;
    tick();

    // idle line (1) keeps the receiver idle
    send_bit(0, 1'b1, 0);
    chk("idle_on_one_busy", 16'(busy0), 16'h0);

    // 1: A5 even parity ok
    send_bit(0, 1'b0, 0);
    chk("start_busy", 16'(busy0), 16'h1);
    for (int i = 0; i < 8; i++) send_bit(0, i[0] ? ((8'hA5 >> i) & 1) != 0 : ((8'hA5 >> i) & 1) != 0, 0);
    send_bit(0, 1'b0, 0);
    chk("t1_valid_before_stop", 16'(data_valid0), 16'h0);
    send_bit(0, 1'b1, 0);
    chk("t1_data_valid", 16'(data_valid0), 16'h1);
    chk("t1_data_out", 16'(data_out0), 16'h00A5);
    chk("t1_parity_err", 16'(parity_err0), 16'h0);
    chk("t1_frame_err", 16'(frame_err0), 16'h0);
    chk("t1_busy", 16'(busy0), 16'h0);
    tick();
    chk("t1_valid_one_cycle", 16'(data_valid0), 16'h0);

    // 2: A5 with wrong parity bit
    send_frame(0, 8'hA5, 1'b1, 1'b1, 0);
    chk("t2_data_valid", 16'(data_valid0), 16'h1);
    chk("t2_parity_err", 16'(parity_err0), 16'h1);
    chk("t2_data_out", 16'(data_out0), 16'h00A5);
    tick();
    chk("t2_perr_one_cycle", 16'(parity_err0), 16'h0);

    // 3: 3C with stop bit 0 -> framing error, data_out untouched
    send_frame(0, 8'h3C, 1'b0, 1'b0, 0);
    chk("t3_frame_err", 16'(frame_err0), 16'h1);
    chk("t3_no_valid", 16'(data_valid0), 16'h0);
    chk("t3_no_perr", 16'(parity_err0), 16'h0);
    chk("t3_data_out_kept", 16'(data_out0), 16'h00A5);
    chk("t3_busy", 16'(busy0), 16'h0);
    tick();
    chk("t3_ferr_one_cycle", 16'(frame_err0), 16'h0);

    // 4: 3C with random strobe gaps
    send_frame(0, 8'h3C, 1'b0, 1'b1, 5);
    chk("t4_data_valid", 16'(data_valid0), 16'h1);
    chk("t4_data_out", 16'(data_out0), 16'h003C);
    chk("t4_parity_err", 16'(parity_err0), 16'h0);
    tick();

    // 5: reset after 4 data bits aborts the frame silently
    send_bit(0, 1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(0, 1'b1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy_after_rst", 16'(busy0), 16'h0);
    chk("t5_no_valid", 16'(data_valid0), 16'h0);
    chk("t5_data_out_rst", 16'(data_out0), 16'h0000);
    send_bit(0, 1'b1, 0);
    send_bit(0, 1'b1, 0);
    chk("t5_no_stray_valid", 16'(data_valid0), 16'h0);
    chk("t5_no_stray_ferr", 16'(frame_err0), 16'h0);
    send_frame(0, 8'h0F, 1'b0, 1'b1, 0);
    chk("t5_data_valid", 16'(data_valid0), 16'h1);
    chk("t5_data_out", 16'(data_out0), 16'h000F);
    chk("t5_parity_err", 16'(parity_err0), 16'h0);
    tick();

    // 6: odd parity, back-to-back frames 00 then FF
    chk("t6_odd_idle_data", 16'(data_out1), 16'h0000);
    chk("t6_odd_idle_busy", 16'(busy1), 16'h0);
    send_frame(1, 8'h00, 1'b1, 1'b1, 0);
    chk("t6_f1_valid", 16'(data_valid1), 16'h1);
    chk("t6_f1_data", 16'(data_out1), 16'h0000);
    chk("t6_f1_perr", 16'(parity_err1), 16'h0);
    send_frame(1, 8'hFF, 1'b1, 1'b1, 0);
    chk("t6_f2_valid", 16'(data_valid1), 16'h1);
    chk("t6_f2_data", 16'(data_out1), 16'h00FF);
    chk("t6_f2_perr", 16'(parity_err1), 16'h0);
    chk("t6_even_untouched", 16'(data_out0), 16'h000F);
    tick();
    chk("t6_valid_one_cycle", 16'(data_valid1), 16'h0);

    // odd instance flags wrong parity (00 with parity 0)
    send_frame(1, 8'h00, 1'b0, 1'b1, 0);
    chk("t6_odd_bad_valid", 16'(data_valid1), 16'h1);
    chk("t6_odd_bad_perr", 16'(parity_err1), 16'h1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
